alu_seq: RTL and testbench

- Sequences the accumulator ALU (opcode/operand/read/write/writeu strobes, accout/flag returns) for two requesters.
- Each request is one accumulator operation. The block loads the left operand into the accumulator, applies the opcode with the right operand, then reads back the result and flag.
- A round-robin arbiter shares the single ALU between requester 0 (core execute) and requester 1 (address/aux unit).
- The block sits between the decode/execute logic and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 16 +
 rtl/rr_arb2.sv | 13 +
 rtl/alu_seq.sv | 137 +++++++++++++
 tb/tb_alu_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants and FSM state encoding for the two-requester accumulator ALU sequencer.
package alu_seq_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 5;
    localparam logic [OP_W-1:0] LOAD_OP = 5'b00000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        READ,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational (zero latency, no backpressure).
// On contention the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);

    assign grant_valid_o = |valid_i;
    assign grant_id_o    = (&valid_i) ? ~last_grant_i : valid_i[1];

endmodule

// File: rtl/alu_seq.sv
// Shares one accumulator ALU between two requesters: load, execute, read back, respond.
// Response 3 edges after accept (2 when load is skipped); a stalled response blocks all new accepts.
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_lhs,
    input  logic [DATA_W-1:0] req0_rhs,
    input  logic              req0_keep,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_lhs,
    input  logic [DATA_W-1:0] req1_rhs,
    input  logic              req1_keep,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_flag,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_operand,
    output logic              alu_read,
    output logic              alu_write,
    output logic              alu_writeu,
    input  logic [DATA_W-1:0] alu_accout,
    input  logic              alu_flag
);

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                acc_valid_q, acc_valid_d;
    logic                id_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   lhs_q, rhs_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_flag_q;

    logic                grant_valid, grant_id, accept;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_lhs, sel_rhs;
    logic                sel_keep;

    rr_arb2 u_arb (
        .valid_i       ({req1_valid, req0_valid}),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    assign accept     = (state_q == IDLE) && grant_valid;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    assign sel_op   = grant_id ? req1_op   : req0_op;
    assign sel_lhs  = grant_id ? req1_lhs  : req0_lhs;
    assign sel_rhs  = grant_id ? req1_rhs  : req0_rhs;
    assign sel_keep = grant_id ? req1_keep : req0_keep;

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_flag   = rsp_flag_q;
    assign alu_writeu = 1'b0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        acc_valid_d  = acc_valid_q;
        alu_opcode   = '0;
        alu_operand  = '0;
        alu_read     = 1'b0;
        alu_write    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // keep is only honoured once the accumulator holds a loaded value
                    state_d      = (sel_keep && acc_valid_q) ? EXEC : LOAD;
                    last_grant_d = grant_id;
                end
            end
            LOAD: begin
                alu_write   = 1'b1;
                alu_opcode  = LOAD_OP;
                alu_operand = lhs_q;
                acc_valid_d = 1'b1;
                state_d     = EXEC;
            end
            EXEC: begin
                alu_opcode  = op_q;
                alu_operand = rhs_q;
                state_d     = READ;
            end
            READ: begin
                alu_read = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            acc_valid_q  <= 1'b0;
            id_q         <= 1'b0;
            op_q         <= '0;
            lhs_q        <= '0;
            rhs_q        <= '0;
            rsp_data_q   <= '0;
            rsp_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            acc_valid_q  <= acc_valid_d;
            if (accept) begin
                id_q  <= grant_id;
                op_q  <= sel_op;
                lhs_q <= sel_lhs;
                rhs_q <= sel_rhs;
            end
            if (state_q == READ) begin
                rsp_data_q <= alu_accout;
                rsp_flag_q <= alu_flag;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq with a behavioural accumulator ALU stub.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_ready, req0_keep;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_lhs, req0_rhs;
    logic              req1_valid, req1_ready, req1_keep;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_lhs, req1_rhs;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_flag;
    logic [DATA_W-1:0] rsp_data;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_operand, alu_accout;
    logic              alu_read, alu_write, alu_writeu, alu_flag;

    alu_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_lhs(req0_lhs), .req0_rhs(req0_rhs), .req0_keep(req0_keep),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_lhs(req1_lhs), .req1_rhs(req1_rhs), .req1_keep(req1_keep),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag),
        .alu_opcode(alu_opcode), .alu_operand(alu_operand), .alu_read(alu_read),
        .alu_write(alu_write), .alu_writeu(alu_writeu),
        .alu_accout(alu_accout), .alu_flag(alu_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                                input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = op[0] ? (a + b) : (a - b);
        return r ^ {{(DATA_W-OP_W){1'b0}}, op};
    endfunction

    // ALU stub: loads on write with LOAD_OP, applies any nonzero opcode otherwise; drives accout only on read
    logic [DATA_W-1:0] stub_acc = '0;
    always @(posedge clk) begin
        if (alu_write && alu_opcode == LOAD_OP) stub_acc <= alu_operand;
        else if (!alu_write && alu_opcode != '0) stub_acc <= alu_f(stub_acc, alu_opcode, alu_operand);
    end
    assign alu_accout = alu_read ? stub_acc : 16'hDEAD;
    assign alu_flag   = alu_read ? ^stub_acc : 1'b0;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] data;
        logic              flag;
        int                due;
    } exp_t;
    exp_t sbq[$];

    // Reference model: who may be accepted, and what the accumulator holds afterwards
    logic              m_busy = 1'b0, m_last = 1'b1, m_accv = 1'b0, prev_rst_low = 1'b0;
    logic [DATA_W-1:0] m_acc = '0;
    logic              m_gv, m_gid, m_load;
    exp_t              m_e;

    always @(negedge clk) begin
        if (prev_rst_low) begin
            check("reset_strobes", {rsp_valid, alu_read, alu_write, alu_writeu, rsp_flag, rsp_id}, 0);
            check("reset_data", {alu_opcode, alu_operand, rsp_data}, 0);
        end
        check("writeu_zero", alu_writeu, 0);
        if (!rst_n) begin
            m_busy = 1'b0; m_last = 1'b1; m_accv = 1'b0;
            sbq.delete();
            prev_rst_low = 1'b1;
        end else begin
            prev_rst_low = 1'b0;
            m_gv  = req0_valid || req1_valid;
            m_gid = (req0_valid && req1_valid) ? !m_last : req1_valid;
            check("req0_ready", req0_ready, !m_busy && m_gv && !m_gid);
            check("req1_ready", req1_ready, !m_busy && m_gv && m_gid);
            if (!m_busy && m_gv) begin
                m_load = !((m_gid ? req1_keep : req0_keep) && m_accv);
                if (m_load) begin
                    m_acc  = m_gid ? req1_lhs : req0_lhs;
                    m_accv = 1'b1;
                end
                m_acc = alu_f(m_acc, m_gid ? req1_op : req0_op, m_gid ? req1_rhs : req0_rhs);
                m_e.id = m_gid; m_e.data = m_acc; m_e.flag = ^m_acc;
                m_e.due = cyc + (m_load ? 4 : 3);
                sbq.push_back(m_e);
                m_last = m_gid;
                m_busy = 1'b1;
            end else if (m_busy && rsp_valid && rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    logic held = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else if (rsp_valid) begin
            if (!held) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    cur = sbq.pop_front();
                    check("rsp_cycle", cyc, cur.due);
                    check("rsp_data", rsp_data, cur.data);
                    check("rsp_flag", rsp_flag, cur.flag);
                    check("rsp_id", rsp_id, cur.id);
                end
            end else begin
                check("hold_data", rsp_data, cur.data);
                check("hold_flag", {rsp_flag, rsp_id}, {cur.flag, cur.id});
            end
            held = !rsp_ready;
        end else begin
            if (held) check("rsp_dropped", 0, 1);
            held = 1'b0;
        end
    end

    task automatic drive_req(input logic id, input logic [OP_W-1:0] op,
                             input logic [DATA_W-1:0] lhs, input logic [DATA_W-1:0] rhs,
                             input logic keep);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_lhs = lhs; req1_rhs = rhs; req1_keep = keep;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_lhs = lhs; req0_rhs = rhs; req0_keep = keep;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_lhs = '0; req0_rhs = '0; req0_keep = 1'b0;
        req1_valid = 1'b0; req1_op = '0; req1_lhs = '0; req1_rhs = '0; req1_keep = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // single op, checking each ALU phase
        drive_req(1'b0, 5'h0B, 16'h7000, 16'h8000, 1'b0);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("load_phase", {alu_write, alu_read, alu_opcode, alu_operand}, {1'b1, 1'b0, 5'h00, 16'h7000});
        @(negedge clk);
        check("exec_phase", {alu_write, alu_read, alu_opcode, alu_operand}, {1'b0, 1'b0, 5'h0B, 16'h8000});
        @(negedge clk);
        check("read_phase", {alu_write, alu_read, alu_opcode, alu_operand}, {1'b0, 1'b1, 5'h00, 16'h0000});
        repeat (4) @(posedge clk);

        // keep right after reset must still load; a second keep must skip the load
        #1 do_reset(2);
        drive_req(1'b1, 5'h05, 16'h1111, 16'h0222, 1'b1);
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        check("keep_forced_load", {alu_write, alu_opcode}, {1'b1, LOAD_OP});
        repeat (5) @(posedge clk);
        #1 drive_req(1'b1, 5'h12, 16'hFFFF, 16'h0345, 1'b1);
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        check("keep_skip_load", {alu_write, alu_opcode, alu_operand}, {1'b0, 5'h12, 16'h0345});
        repeat (5) @(posedge clk);

        // backpressure: response held while a new request waits
        #1 drive_req(1'b0, 5'h03, 16'h4321, 16'h0101, 1'b0);
        rsp_ready = 1'b0;
        @(posedge clk); #1 req0_valid = 1'b0;
        for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
        if (!rsp_valid) check("bp_rsp_timeout", 0, 1);
        @(posedge clk); #1 drive_req(1'b0, 5'h07, 16'h0F0F, 16'h00F0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10 && !req0_ready; i++) @(negedge clk);
        if (!req0_ready) check("bp_accept_timeout", 0, 1);
        @(posedge clk); #1 req0_valid = 1'b0;
        repeat (6) @(posedge clk);

        // reset during EXEC drops the op; following keep request must reload
        #1 drive_req(1'b0, 5'h09, 16'h2468, 16'h1357, 1'b0);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        drive_req(1'b0, 5'h0D, 16'hABCD, 16'h0011, 1'b1);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("reset_then_load", {alu_write, alu_operand}, {1'b1, 16'hABCD});
        repeat (5) @(posedge clk);

        // random contention, withdrawals, keep, backpressure and occasional reset
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst_n      = ($urandom_range(0, 149) != 0);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_op    = OP_W'($urandom_range(1, 31));
            req1_op    = OP_W'($urandom_range(1, 31));
            req0_lhs   = DATA_W'($urandom); req0_rhs = DATA_W'($urandom);
            req1_lhs   = DATA_W'($urandom); req1_rhs = DATA_W'($urandom);
            req0_keep  = $urandom_range(0, 1) != 0;
            req1_keep  = $urandom_range(0, 1) != 0;
        end

        @(posedge clk); #1;
        rst_n = 1'b1; rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("drain_queue", sbq.size(), 0);
        check("drain_idle", m_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
